hermes_vc_buffer: RTL

Input-port queue for a Hermes router with `NUM_VC` independent virtual channels. Each channel is a credit-based circular FIFO with its own packet-framing FSM (request, header, size, payload, end). One shared input link fills the queues; each channel has its own output handshake toward the switch control and crossbar. Added behaviour: a per-channel occupancy count, correct handling of zero-length payloads, and FSM advances only on real pops.

---
 rtl/hermes_vc_buffer_if.sv | 32 +++
 rtl/hermes_vc_buffer.sv | 107 ++++++++++
 2 files changed

// File: rtl/hermes_vc_buffer_if.sv
// Link bundle of the Hermes virtual-channel input buffer: the shared input link
// plus the per-channel handshakes toward switch control and the crossbar.
interface hermes_vc_buffer_if #(
  parameter int NUM_VC      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 32
);
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CW = $clog2(BUFFER_SIZE) + 1;

  logic                        rx_i;
  logic [VW-1:0]               vc_i;
  logic [FLIT_SIZE-1:0]        data_i;
  logic [NUM_VC-1:0]           credit_o;
  logic [NUM_VC-1:0]           req_o;
  logic [NUM_VC-1:0]           req_ack_i;
  logic [NUM_VC-1:0]           data_av_o;
  logic [NUM_VC-1:0]           data_ack_i;
  logic [NUM_VC-1:0]           sending_o;
  logic [NUM_VC*FLIT_SIZE-1:0] data_o;
  logic [NUM_VC*CW-1:0]        count_o;

  modport slave (
    input  rx_i, vc_i, data_i, req_ack_i, data_ack_i,
    output credit_o, req_o, data_av_o, sending_o, data_o, count_o
  );

  modport master (
    output rx_i, vc_i, data_i, req_ack_i, data_ack_i,
    input  credit_o, req_o, data_av_o, sending_o, data_o, count_o
  );
endinterface

// File: rtl/hermes_vc_buffer.sv
// Hermes router input port: NUM_VC independent credit-based circular FIFOs fed by
// one shared link, each with its own packet-framing FSM toward the switch.
module hermes_vc_buffer #(
  parameter int NUM_VC      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 32
) (
  input logic               clk_i,
  input logic               rst_ni,
  hermes_vc_buffer_if.slave link
);
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CW = $clog2(BUFFER_SIZE) + 1;
  localparam int PW = $clog2(BUFFER_SIZE);

  typedef enum logic [6:0] {
    S_INIT    = 7'b0000001,
    S_REQ     = 7'b0000010,
    S_HEADER  = 7'b0000100,
    S_SIZE    = 7'b0001000,
    S_PAYLOAD = 7'b0010000,
    S_END     = 7'b0100000,
    S_END2    = 7'b1000000
  } state_t;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [CW-1:0]        count;
    logic [FLIT_SIZE-1:0] flit_cntr;
    logic [FLIT_SIZE-1:0] flit_cntr_next;
    logic [FLIT_SIZE-1:0] tail_flit;
    state_t               state;
    state_t               state_next;
    logic                 push;
    logic                 pop;
    logic                 sending;
    logic                 not_full;
    logic                 not_empty;

    assign not_full  = (count != CW'(BUFFER_SIZE));
    assign not_empty = (count != '0);
    assign tail_flit = mem[tail];
    assign sending   = (state == S_HEADER) || (state == S_SIZE) || (state == S_PAYLOAD);
    assign push      = link.rx_i && (link.vc_i == VW'(v)) && not_full;
    // An ack on an empty channel is not a pop, so it must never move the FSM.
    assign pop       = sending && link.data_ack_i[v] && not_empty;

    // Flit storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[head] <= link.data_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        flit_cntr <= '0;
        state     <= S_INIT;
      end else begin
        if (push) head <= head + PW'(1);
        if (pop)  tail <= tail + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
        flit_cntr <= flit_cntr_next;
        state     <= state_next;
      end
    end

    // A size flit of zero ends the packet right after SIZE.
    always_comb begin
      state_next     = state;
      flit_cntr_next = flit_cntr;
      case (state)
        S_INIT:    if (not_empty) state_next = S_REQ;
        S_REQ:     if (link.req_ack_i[v]) state_next = S_HEADER;
        S_HEADER:  if (pop) state_next = S_SIZE;
        S_SIZE: begin
          if (pop) begin
            flit_cntr_next = tail_flit;
            state_next     = (tail_flit == '0) ? S_END : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (pop) begin
            flit_cntr_next = flit_cntr - FLIT_SIZE'(1);
            if (flit_cntr == FLIT_SIZE'(1)) state_next = S_END;
          end
        end
        S_END:     state_next = S_END2;
        S_END2:    state_next = S_INIT;
        default:   state_next = S_INIT;
      endcase
    end

    assign link.credit_o[v]                 = not_full;
    assign link.req_o[v]                    = (state == S_REQ);
    assign link.sending_o[v]                = sending;
    assign link.data_av_o[v]                = sending && not_empty;
    assign link.data_o[v*FLIT_SIZE +: FLIT_SIZE] = tail_flit;
    assign link.count_o[v*CW +: CW]         = count;
  end
endmodule
